mem_access_unit: RTL and testbench

MEM-stage load/store unit for the pipelined MIPS core. It narrows register data into byte lanes for `sb`/`sh`/`sw`, and extracts and sign- or zero-extends memory data for `lb`/`lbu`/`lh`/`lhu`/`lw`. It sits between the MEM pipeline register and a word-wide data memory. The memory has a ready handshake, and the unit stalls the pipeline until each access completes.

---
 rtl/mem_access_unit.sv | 170 +++++++++++++++++
 tb/tb_mem_access_unit.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_unit
// Purpose  : MEM-stage load/store unit for the pipelined MIPS core. Narrows
//            register data into byte lanes for sb/sh/sw and extracts and
//            sign/zero-extends memory data for lb/lbu/lh/lhu/lw. Talks to a
//            word-wide data memory with a ready handshake and stalls the
//            pipeline until each access completes.
// Ports    :
//   clk, reset        - clock, synchronous active-high reset
//   req, we, size,    - MEM-stage request: load/store, size (0 B, 1 H, 2 W,
//   sign, addr, wdata   3 illegal), load extension, byte address, store data
//   stall             - freezes PC and F/D/E/M pipeline registers
//   misalign          - address-error flag for the current request
//   rdata, rvalid     - registered load result and its one-cycle valid pulse
//   mem_en, mem_we,   - memory strobe, write, word address, byte enables,
//   mem_addr, mem_be,   lane-replicated write data
//   mem_wdata
//   mem_ready,        - memory completion and read data
//   mem_rdata
// Revision : 1.0 - initial release
// ============================================================================
module mem_access_unit #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              we,
  input  logic [1:0]        size,
  input  logic              sign,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              stall,
  output logic              misalign,
  output logic [31:0]       rdata,
  output logic              rvalid,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ready,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t            state;
  logic              lat_we;
  logic [1:0]        lat_size;
  logic              lat_sign;
  logic [ADDR_W-1:0] lat_addr;
  logic [31:0]       lat_wdata;

  logic        aligned;
  logic        start;
  logic        busy;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_val;

  // Alignment of the incoming request; size 3 is never legal.
  always_comb begin
    aligned = 1'b0;
    case (size)
      2'd0:    aligned = 1'b1;
      2'd1:    aligned = ~addr[0];
      2'd2:    aligned = (addr[1:0] == 2'b00);
      default: aligned = 1'b0;
    endcase
  end

  assign busy     = (state == BUSY);
  assign start    = (state == IDLE) && req && aligned;
  assign misalign = (state == IDLE) && req && !aligned;
  assign stall    = start || (busy && !mem_ready);

  // Memory-side outputs depend only on state and latched request, so input
  // changes during a wait cannot disturb an access in flight.
  assign mem_en   = busy;
  assign mem_we   = busy && lat_we;
  assign mem_addr = busy ? {lat_addr[ADDR_W-1:2], 2'b00} : '0;

  always_comb begin
    mem_be    = 4'b0000;
    mem_wdata = 32'h0;
    if (busy) begin
      if (lat_we) begin
        case (lat_size)
          2'd0: begin
            mem_be    = 4'b0001 << lat_addr[1:0];
            mem_wdata = {4{lat_wdata[7:0]}};
          end
          2'd1: begin
            mem_be    = lat_addr[1] ? 4'b1100 : 4'b0011;
            mem_wdata = {2{lat_wdata[15:0]}};
          end
          default: begin
            mem_be    = 4'b1111;
            mem_wdata = lat_wdata;
          end
        endcase
      end else begin
        mem_be    = 4'b1111;
        mem_wdata = 32'h0;
      end
    end
  end

  // Lane selection and extension of the returned word for loads.
  always_comb begin
    ld_byte = 8'h0;
    case (lat_addr[1:0])
      2'd0:    ld_byte = mem_rdata[7:0];
      2'd1:    ld_byte = mem_rdata[15:8];
      2'd2:    ld_byte = mem_rdata[23:16];
      default: ld_byte = mem_rdata[31:24];
    endcase
    ld_half = lat_addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (lat_size)
      2'd0:    ld_val = {{24{lat_sign & ld_byte[7]}}, ld_byte};
      2'd1:    ld_val = {{16{lat_sign & ld_half[15]}}, ld_half};
      default: ld_val = mem_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      lat_we    <= 1'b0;
      lat_size  <= 2'd0;
      lat_sign  <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= 32'h0;
      rdata     <= 32'h0;
      rvalid    <= 1'b0;
    end else begin
      rvalid <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            lat_we    <= we;
            lat_size  <= size;
            lat_sign  <= sign;
            lat_addr  <= addr;
            lat_wdata <= wdata;
            state     <= BUSY;
          end
        end
        BUSY: begin
          if (mem_ready) begin
            state <= IDLE;
            // Stores complete silently; rdata keeps the last load result.
            if (!lat_we) begin
              rdata  <= ld_val;
              rvalid <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_access_unit
// Purpose  : Self-checking bench for mem_access_unit with directed cases and
//            randomized load/store traffic against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req;
  logic        we;
  logic [1:0]  size;
  logic        sign;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        stall;
  logic        misalign;
  logic [31:0] rdata;
  logic        rvalid;
  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] model_rdata = 32'h0;
  logic        exp_rvalid  = 1'b0;

  mem_access_unit #(.ADDR_W(32)) dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .size(size), .sign(sign),
    .addr(addr), .wdata(wdata), .stall(stall), .misalign(misalign),
    .rdata(rdata), .rvalid(rvalid), .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic bit ref_aligned(input int sz, input logic [31:0] a);
    return (sz == 0) || (sz == 1 && a % 2 == 0) || (sz == 2 && a % 4 == 0);
  endfunction

  function automatic logic [31:0] ref_load(input int sz, input bit sg,
                                           input logic [31:0] a, input logic [31:0] w);
    logic [31:0] v;
    if (sz == 0) begin
      v = (w >> (8 * (a % 4))) & 32'hFF;
      if (sg && v >= 32'h80) v = v | 32'hFFFF_FF00;
    end else if (sz == 1) begin
      v = (w >> (16 * ((a / 2) % 2))) & 32'hFFFF;
      if (sg && v >= 32'h8000) v = v | 32'hFFFF_0000;
    end else begin
      v = w;
    end
    return v;
  endfunction

  function automatic logic [31:0] ref_be(input bit w, input int sz, input logic [31:0] a);
    if (!w || sz == 2) return 32'hF;
    if (sz == 0) return 32'h1 << (a % 4);
    return 32'h3 << (2 * ((a / 2) % 2));
  endfunction

  function automatic logic [31:0] ref_wd(input bit w, input int sz, input logic [31:0] d);
    if (!w) return 32'h0;
    if (sz == 0) return (d & 32'hFF) * 32'h0101_0101;
    if (sz == 1) return (d & 32'hFFFF) * 32'h0001_0001;
    return d;
  endfunction

  // One access starting in IDLE; entry/exit just after a rising edge.
  task automatic access(input bit a_we, input int a_size, input bit a_sign,
                        input logic [31:0] a_addr, input logic [31:0] a_wdata,
                        input logic [31:0] a_word, input int waits);
    bit al;
    al = ref_aligned(a_size, a_addr);
    req = 1'b1; we = a_we; size = 2'(a_size); sign = a_sign;
    addr = a_addr; wdata = a_wdata;
    mem_ready = 1'($urandom);   // ignored in IDLE
    mem_rdata = $urandom;
    @(negedge clk);
    check("rvalid_c0", rvalid, exp_rvalid);
    check("rdata_c0", rdata, model_rdata);
    check("misalign_c0", misalign, !al);
    check("stall_c0", stall, al);
    check("mem_en_c0", mem_en, 1'b0);
    @(posedge clk); #1;
    exp_rvalid = 1'b0;
    if (!al) begin
      req = 1'b0; mem_ready = 1'b0;
      return;
    end
    for (int i = 0; i <= waits; i++) begin
      mem_ready = (i == waits);
      mem_rdata = (i == waits) ? a_word : $urandom;
      // Scramble request inputs; a BUSY access must ignore them.
      addr = $urandom; wdata = $urandom; we = 1'($urandom);
      size = 2'($urandom); sign = 1'($urandom); req = 1'($urandom);
      @(negedge clk);
      check("mem_en", mem_en, 1'b1);
      check("mem_we", mem_we, a_we);
      check("mem_addr", mem_addr, a_addr & 32'hFFFF_FFFC);
      check("mem_be", mem_be, ref_be(a_we, a_size, a_addr));
      check("mem_wdata", mem_wdata, ref_wd(a_we, a_size, a_wdata));
      check("stall_busy", stall, i != waits);
      check("misalign_busy", misalign, 1'b0);
      check("rvalid_busy", rvalid, 1'b0);
      @(posedge clk); #1;
    end
    if (!a_we) model_rdata = ref_load(a_size, a_sign, a_addr, a_word);
    exp_rvalid = !a_we;
    req = 1'b0; mem_ready = 1'b0;
  endtask

  task automatic idle_cycle();
    req = 1'b0;
    mem_ready = 1'($urandom);
    mem_rdata = $urandom;
    @(negedge clk);
    check("rvalid_idle", rvalid, exp_rvalid);
    check("rdata_idle", rdata, model_rdata);
    check("stall_idle", stall, 1'b0);
    check("misalign_idle", misalign, 1'b0);
    check("mem_en_idle", mem_en, 1'b0);
    @(posedge clk); #1;
    exp_rvalid = 1'b0;
    mem_ready = 1'b0;
  endtask

  initial begin
    int sz;
    logic [31:0] a;
    reset = 1'b1; req = 1'b0; we = 1'b0; size = 2'd0; sign = 1'b0;
    addr = 32'h0; wdata = 32'h0; mem_ready = 1'b0; mem_rdata = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_mem_en", mem_en, 1'b0);
    check("rst_mem_we", mem_we, 1'b0);
    check("rst_mem_be", mem_be, 4'b0000);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    check("rst_stall", stall, 1'b0);
    check("rst_misalign", misalign, 1'b0);
    check("rst_rdata", rdata, 32'h0);
    check("rst_rvalid", rvalid, 1'b0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Directed cases, back to back.
    access(1'b0, 0, 1'b1, 32'h1003, 32'h0, 32'h80FF_1234, 0);   // lb
    access(1'b0, 1, 1'b0, 32'h2002, 32'h0, 32'h9ABC_0001, 0);   // lhu
    access(1'b0, 1, 1'b1, 32'h2002, 32'h0, 32'h9ABC_0001, 0);   // lh
    access(1'b1, 0, 1'b0, 32'h11, 32'h1234_56A5, $urandom, 0);  // sb
    access(1'b1, 1, 1'b0, 32'h12, 32'h0000_BEEF, $urandom, 0);  // sh
    access(1'b0, 2, 1'b0, 32'h40, 32'h0, 32'hCAFE_F00D, 3);     // lw, 3 waits
    access(1'b1, 1, 1'b0, 32'h03, 32'h5555_5555, 32'h0, 0);     // sh misaligned
    access(1'b0, 2, 1'b0, 32'h02, 32'h0, 32'h0, 0);             // lw misaligned
    access(1'b0, 3, 1'b0, 32'h00, 32'h0, 32'h0, 0);             // illegal size
    idle_cycle();

    // Randomized traffic.
    for (int n = 0; n < 300; n++) begin
      sz = (($urandom % 8) == 0) ? 3 : int'($urandom % 3);
      a  = $urandom;
      if (($urandom % 4) != 0) begin
        if (sz == 1) a[0] = 1'b0;
        if (sz == 2) a[1:0] = 2'b00;
      end
      access(1'($urandom), sz, 1'($urandom), a, $urandom, $urandom, int'($urandom % 4));
      if (($urandom % 4) == 0) idle_cycle();
    end

    // Make sure rdata is non-zero before the reset-abort case.
    access(1'b0, 2, 1'b0, 32'h80, 32'h0, 32'h1357_2468, 0);
    idle_cycle();

    // Reset in the second BUSY cycle of a waiting load.
    req = 1'b1; we = 1'b0; size = 2'd2; sign = 1'b0; addr = 32'h100; mem_ready = 1'b0;
    @(negedge clk);
    check("rst_abort_stall", stall, 1'b1);
    @(posedge clk); #1;
    req = 1'b0;
    @(negedge clk);
    check("rst_abort_busy1", mem_en, 1'b1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    check("rst_abort_busy2", mem_en, 1'b1);
    @(posedge clk); #1;
    reset = 1'b0;
    model_rdata = 32'h0;
    exp_rvalid  = 1'b0;
    @(negedge clk);
    check("rst_abort_mem_en", mem_en, 1'b0);
    check("rst_abort_rdata", rdata, 32'h0);
    check("rst_abort_rvalid", rvalid, 1'b0);
    check("rst_abort_stall2", stall, 1'b0);
    @(posedge clk); #1;
    mem_ready = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    mem_ready = 1'b0;
    @(negedge clk);
    check("late_ready_rvalid", rvalid, 1'b0);
    check("late_ready_rdata", rdata, 32'h0);
    check("late_ready_mem_en", mem_en, 1'b0);
    @(posedge clk); #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
